// File: rtl/gm64_pkg.sv
// Shared types and constants for the gm64 memory arbiter.
// Holds the arbiter state encoding, requester identity and default address bases.
package gm64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_ACK
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VIC = 1'b1
  } requester_e;

  localparam logic [23:0] DEFAULT_CPU_BASE = 24'h000000;
  localparam logic [23:0] DEFAULT_VIC_BASE = 24'h000000;
  localparam logic [15:0] DEFAULT_TIMEOUT  = 16'd1023;

  // C64 16-bit address into the 24-bit PSRAM space; wrapping past 2^24 is intended.
  function automatic logic [23:0] map_addr(input logic [23:0] base,
                                           input logic [15:0] addr);
    return base + {8'h00, addr};
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-way alternating-priority picker: a lone requester wins, a tie goes to
// whichever requester did not win last time.
module mem_arb_grant
  import gm64_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       vic_req_i,
  input  requester_e last_grant_i,
  output logic       valid_o,
  output requester_e grant_o
);

  always_comb begin
    valid_o = cpu_req_i | vic_req_i;
    grant_o = REQ_CPU;
    if (cpu_req_i && vic_req_i) begin
      grant_o = (last_grant_i == REQ_CPU) ? REQ_VIC : REQ_CPU;
    end else if (vic_req_i) begin
      grant_o = REQ_VIC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the PSRAM controller between the CPU (read/write) and VIC (read-only)
// ports, sequencing the controller's cs/busy/dataReady handshake.
module mem_arbiter
  import gm64_pkg::*;
#(
  parameter logic [23:0] CPU_BASE = DEFAULT_CPU_BASE,
  parameter logic [23:0] VIC_BASE = DEFAULT_VIC_BASE,
  parameter logic [15:0] TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic        clkSys,
  input  logic        reset,
  input  logic        i_cpuReq,
  input  logic        i_cpuWrite,
  input  logic [15:0] i_cpuAddr,
  input  logic [7:0]  i_cpuData,
  output logic        o_cpuAck,
  output logic [7:0]  o_cpuData,
  input  logic        i_vicReq,
  input  logic [15:0] i_vicAddr,
  output logic        o_vicAck,
  output logic [7:0]  o_vicData,
  output logic        o_cs,
  output logic        o_write,
  output logic [23:0] o_address,
  output logic [7:0]  o_dataToWrite,
  input  logic [7:0]  i_dataRead,
  input  logic        i_busy,
  input  logic        i_dataReady,
  output logic        o_timeout
);

  arb_state_e  state_q, state_d;
  requester_e  grant_q, grant_d;
  requester_e  last_grant_q, last_grant_d;
  logic        write_q, write_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic [7:0]  vic_data_q, vic_data_d;
  logic        timeout_q, timeout_d;
  logic [15:0] cnt_q, cnt_d;

  logic        pick_valid;
  requester_e  pick;
  logic        txn_done;
  logic        cnt_expired;

  mem_arb_grant u_grant (
    .cpu_req_i    (i_cpuReq),
    .vic_req_i    (i_vicReq),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .grant_o      (pick)
  );

  // Writes finish when the controller drops busy; reads also need dataReady.
  assign txn_done    = !i_busy && (write_q || i_dataReady);
  assign cnt_expired = (cnt_q == TIMEOUT - 16'd1);

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_data_d   = cpu_data_q;
    vic_data_d   = vic_data_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!i_busy && pick_valid) begin
          state_d      = ST_ISSUE;
          grant_d      = pick;
          last_grant_d = pick;
          if (pick == REQ_CPU) begin
            write_d = i_cpuWrite;
            addr_d  = map_addr(CPU_BASE, i_cpuAddr);
            wdata_d = i_cpuData;
          end else begin
            write_d = 1'b0;
            addr_d  = map_addr(VIC_BASE, i_vicAddr);
            wdata_d = 8'h00;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end

      ST_WAIT_START: begin
        cnt_d = cnt_q + 16'd1;
        if (i_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_ACK;
        end
      end

      ST_WAIT_DONE: begin
        cnt_d = cnt_q + 16'd1;
        if (txn_done) begin
          if (!write_q) begin
            if (grant_q == REQ_CPU) cpu_data_d = i_dataRead;
            else                    vic_data_d = i_dataRead;
          end
          state_d = ST_ACK;
        end else if (cnt_expired) begin
          // Abort path: read data is left untouched, the requester still gets its ack.
          timeout_d = 1'b1;
          state_d   = ST_ACK;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkSys or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_CPU;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_data_q   <= '0;
      vic_data_q   <= '0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_data_q   <= cpu_data_d;
      vic_data_q   <= vic_data_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // Strobes decode straight from the state register, so reset forces them inactive at once.
  assign o_cs          = (state_q != ST_ISSUE);
  assign o_cpuAck      = (state_q == ST_ACK) && (grant_q == REQ_CPU);
  assign o_vicAck      = (state_q == ST_ACK) && (grant_q == REQ_VIC);
  assign o_write       = write_q;
  assign o_address     = addr_q;
  assign o_dataToWrite = wdata_q;
  assign o_cpuData     = cpu_data_q;
  assign o_vicData     = vic_data_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances with different bases share all
// inputs; a memCtrl model answers dut_a's chip select.
module tb_mem_arbiter;
  import gm64_pkg::*;

  logic clkSys = 1'b0;
  always #5 clkSys = ~clkSys;

  logic        reset;
  logic        cpu_req, cpu_write, vic_req;
  logic [15:0] cpu_addr, vic_addr;
  logic [7:0]  cpu_wdata;
  logic        busy = 1'b0;
  logic        data_ready = 1'b0;
  logic [7:0]  data_read = 8'h00;

  logic        a_cpu_ack, a_vic_ack, a_cs, a_write, a_timeout;
  logic [7:0]  a_cpu_data, a_vic_data, a_wdata;
  logic [23:0] a_addr;
  logic        b_cpu_ack, b_vic_ack, b_cs, b_write, b_timeout;
  logic [7:0]  b_cpu_data, b_vic_data, b_wdata;
  logic [23:0] b_addr;

  mem_arbiter #(.CPU_BASE(24'h000000), .VIC_BASE(24'h010000), .TIMEOUT(16'd16)) dut_a (
    .clkSys(clkSys), .reset(reset),
    .i_cpuReq(cpu_req), .i_cpuWrite(cpu_write), .i_cpuAddr(cpu_addr), .i_cpuData(cpu_wdata),
    .o_cpuAck(a_cpu_ack), .o_cpuData(a_cpu_data),
    .i_vicReq(vic_req), .i_vicAddr(vic_addr), .o_vicAck(a_vic_ack), .o_vicData(a_vic_data),
    .o_cs(a_cs), .o_write(a_write), .o_address(a_addr), .o_dataToWrite(a_wdata),
    .i_dataRead(data_read), .i_busy(busy), .i_dataReady(data_ready), .o_timeout(a_timeout)
  );

  mem_arbiter #(.CPU_BASE(24'hffff00), .VIC_BASE(24'h000000), .TIMEOUT(16'd16)) dut_b (
    .clkSys(clkSys), .reset(reset),
    .i_cpuReq(cpu_req), .i_cpuWrite(cpu_write), .i_cpuAddr(cpu_addr), .i_cpuData(cpu_wdata),
    .o_cpuAck(b_cpu_ack), .o_cpuData(b_cpu_data),
    .i_vicReq(vic_req), .i_vicAddr(vic_addr), .o_vicAck(b_vic_ack), .o_vicData(b_vic_data),
    .o_cs(b_cs), .o_write(b_write), .o_address(b_addr), .o_dataToWrite(b_wdata),
    .i_dataRead(data_read), .i_busy(busy), .i_dataReady(data_ready), .o_timeout(b_timeout)
  );

  // memCtrl model: busy for mdl_busy_len cycles starting the cycle after cs low.
  int unsigned mdl_busy_len = 1;
  logic        mdl_dead = 1'b0;
  logic [7:0]  mdl_rdata = 8'h00;
  int unsigned mdl_cnt = 0;
  logic        mdl_read = 1'b0;

  always @(posedge clkSys) begin
    data_ready <= 1'b0;
    if (!a_cs && !mdl_dead) begin
      busy     <= 1'b1;
      mdl_cnt  <= mdl_busy_len;
      mdl_read <= !a_write;
    end else if (busy) begin
      if (mdl_cnt <= 1) begin
        busy       <= 1'b0;
        data_ready <= mdl_read;
        data_read  <= mdl_rdata;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  typedef struct {
    requester_e  who;
    logic        write;
    logic [23:0] addr_a;
    logic [23:0] addr_b;
    logic [7:0]  wdata;
  } issue_t;

  typedef struct {
    requester_e who;
    logic [7:0] rdata;
    logic       timeout;
    int         lat;
  } ack_t;

  issue_t issue_q[$];
  ack_t   ack_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int issue_cnt = 0;
  int ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clkSys) begin : monitor
    issue_t ie;
    ack_t   ae;
    cyc++;
    if (reset) begin
      if (!a_cs) begin
        if (issue_q.size() == 0) begin
          check("unexpected_cs", 32'(a_cs), 32'd1);
        end else begin
          ie = issue_q.pop_front();
          check("issue_write", 32'(a_write), 32'(ie.write));
          check("issue_addr_a", 32'(a_addr), 32'(ie.addr_a));
          check("issue_addr_b", 32'(b_addr), 32'(ie.addr_b));
          check("issue_cs_b", 32'(b_cs), 32'd0);
          if (ie.write) check("issue_wdata", 32'(a_wdata), 32'(ie.wdata));
          issue_cyc = cyc;
          issue_cnt++;
        end
      end
      if (a_cpu_ack || a_vic_ack) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 32'({a_cpu_ack, a_vic_ack}), 32'd0);
        end else begin
          ae = ack_q.pop_front();
          check("ack_sel", 32'({a_cpu_ack, a_vic_ack}), (ae.who == REQ_CPU) ? 32'd2 : 32'd1);
          check("ack_sel_b", 32'({b_cpu_ack, b_vic_ack}), (ae.who == REQ_CPU) ? 32'd2 : 32'd1);
          check("ack_data", 32'((ae.who == REQ_CPU) ? a_cpu_data : a_vic_data), 32'(ae.rdata));
          check("ack_timeout", 32'(a_timeout), 32'(ae.timeout));
          // Grant cycle counted as cycle 1; it is the cycle before cs goes low.
          if (ae.lat != 0) check("ack_latency", 32'(cyc - issue_cyc + 2), 32'(ae.lat));
          ack_cnt++;
        end
      end
    end
  end

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      @(negedge clkSys); #1;
      n++;
    end
    if (ack_cnt < target) check("ack_wait_bound", 32'(ack_cnt), 32'(target));
  endtask

  task automatic cpu_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                         input int b, input logic [7:0] rd, input logic [23:0] ea,
                         input logic [23:0] eb, input logic [7:0] exp_data,
                         input logic exp_to, input int lat);
    int target = ack_cnt + 1;
    mdl_busy_len = b;
    mdl_rdata    = rd;
    issue_q.push_back('{who: REQ_CPU, write: wr, addr_a: ea, addr_b: eb, wdata: wd});
    ack_q.push_back('{who: REQ_CPU, rdata: exp_data, timeout: exp_to, lat: lat});
    cpu_write = wr; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    wait_acks(target, 200);
    cpu_req = 1'b0;
  endtask

  task automatic vic_txn(input logic [15:0] addr, input int b, input logic [7:0] rd,
                         input logic [23:0] ea, input logic [23:0] eb,
                         input logic exp_to, input int lat);
    int target = ack_cnt + 1;
    mdl_busy_len = b;
    mdl_rdata    = rd;
    issue_q.push_back('{who: REQ_VIC, write: 1'b0, addr_a: ea, addr_b: eb, wdata: 8'h00});
    ack_q.push_back('{who: REQ_VIC, rdata: rd, timeout: exp_to, lat: lat});
    vic_addr = addr; vic_req = 1'b1;
    wait_acks(target, 200);
    vic_req = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_cs", 32'(a_cs), 32'd1);
    check("rst_cs_b", 32'(b_cs), 32'd1);
    check("rst_write", 32'(a_write), 32'd0);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_wdata", 32'(a_wdata), 32'd0);
    check("rst_acks", 32'({a_cpu_ack, a_vic_ack}), 32'd0);
    check("rst_cpu_data", 32'(a_cpu_data), 32'd0);
    check("rst_vic_data", 32'(a_vic_data), 32'd0);
    check("rst_timeout", 32'(a_timeout), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clkSys); #1;
    reset = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clkSys);
    #1 reset = 1'b1;
  endtask

  initial begin
    int target;
    int n;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vic_req = 1'b0; vic_addr = '0;
    #1 check_reset_values();
    repeat (3) @(negedge clkSys);
    #1 reset = 1'b1;
    repeat (2) @(negedge clkSys);
    #1;

    // CPU write, B=5: wrap on dut_b (ffff00 + fffc = 00fefc), ack in cycle 9.
    cpu_txn(1'b1, 16'hfffc, 8'haa, 5, 8'h00, 24'h00fffc, 24'h00fefc, 8'h00, 1'b0, 9);
    // VIC read through VIC_BASE=010000.
    vic_txn(16'h0400, 4, 8'h5c, 24'h010400, 24'h000400, 1'b0, 8);
    // CPU read: dut_b wraps ffff00 + 0200 to 000100.
    cpu_txn(1'b0, 16'h0200, 8'h00, 1, 8'hc3, 24'h000200, 24'h000100, 8'hc3, 1'b0, 5);
    // CPU write leaves the previous read data in place.
    cpu_txn(1'b1, 16'h0003, 8'h11, 2, 8'h00, 24'h000003, 24'hffff03, 8'hc3, 1'b0, 6);

    // Both requesting continuously after reset: VIC wins first, then strict alternation.
    pulse_reset();
    mdl_busy_len = 2;
    mdl_rdata    = 8'h77;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        issue_q.push_back('{who: REQ_VIC, write: 1'b0, addr_a: 24'h010800, addr_b: 24'h000800, wdata: 8'h00});
        ack_q.push_back('{who: REQ_VIC, rdata: 8'h77, timeout: 1'b0, lat: 6});
      end else begin
        issue_q.push_back('{who: REQ_CPU, write: 1'b0, addr_a: 24'h001234, addr_b: 24'h001134, wdata: 8'h00});
        ack_q.push_back('{who: REQ_CPU, rdata: 8'h77, timeout: 1'b0, lat: 6});
      end
    end
    target = ack_cnt + 6;
    cpu_write = 1'b0; cpu_addr = 16'h1234; vic_addr = 16'h0800;
    cpu_req = 1'b1; vic_req = 1'b1;
    wait_acks(target, 300);
    cpu_req = 1'b0; vic_req = 1'b0;

    // Controller never answers: abort after 16 wait cycles (2 + 16 + 1 = 19), data kept.
    mdl_dead = 1'b1;
    cpu_txn(1'b0, 16'h0010, 8'h00, 1, 8'hee, 24'h000010, 24'hffff10, 8'h77, 1'b1, 19);
    mdl_dead = 1'b0;
    repeat (3) @(negedge clkSys);
    #1 check("timeout_sticky", 32'(a_timeout), 32'd1);
    vic_txn(16'h0001, 3, 8'h81, 24'h010001, 24'h000001, 1'b1, 7);

    // Reset in WAIT_DONE: no ack; the held request is granted again afterwards.
    mdl_busy_len = 8;
    mdl_rdata    = 8'h42;
    issue_q.push_back('{who: REQ_CPU, write: 1'b0, addr_a: 24'h000040, addr_b: 24'hffff40, wdata: 8'h00});
    target = issue_cnt + 1;
    cpu_write = 1'b0; cpu_addr = 16'h0040; cpu_req = 1'b1;
    n = 0;
    while (issue_cnt < target && n < 50) begin
      @(negedge clkSys); #1;
      n++;
    end
    if (issue_cnt < target) check("issue_wait_bound", 32'(issue_cnt), 32'(target));
    repeat (2) @(negedge clkSys);
    #1 reset = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clkSys);
    issue_q.push_back('{who: REQ_CPU, write: 1'b0, addr_a: 24'h000040, addr_b: 24'hffff40, wdata: 8'h00});
    ack_q.push_back('{who: REQ_CPU, rdata: 8'h42, timeout: 1'b0, lat: 12});
    target = ack_cnt + 1;
    #1 reset = 1'b1;
    wait_acks(target, 200);
    cpu_req = 1'b0;

    repeat (4) @(negedge clkSys);
    #1;
    check("issue_q_drained", 32'(issue_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
